// File: rtl/seletor_7seg_mux.sv
// Time-multiplexed N-digit 7-segment driver: prescaled one-hot anode scan, hex decode,
// blanking with leading-zero suppression, anti-ghosting dead time, frame-coherent data snapshot.
module seletor_7seg_mux #(
    parameter int N_DIGITS       = 4,
    parameter int DIV            = 50000,
    parameter int DEAD           = 500,
    parameter bit AC_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic                  lz_blank,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [N_DIGITS-1:0]   AC,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_DEAD = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AC_OFF   = {N_DIGITS{AC_ACTIVE_LOW}};
    localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                DP_OFF   = SEG_ACTIVE_LOW;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        code = 7'h00;
        case (nib)
            4'h0: code = 7'h3F;
            4'h1: code = 7'h06;
            4'h2: code = 7'h5B;
            4'h3: code = 7'h4F;
            4'h4: code = 7'h66;
            4'h5: code = 7'h6D;
            4'h6: code = 7'h7D;
            4'h7: code = 7'h07;
            4'h8: code = 7'h7F;
            4'h9: code = 7'h6F;
            4'hA: code = 7'h77;
            4'hB: code = 7'h7C;
            4'hC: code = 7'h39;
            4'hD: code = 7'h5E;
            4'hE: code = 7'h79;
            4'hF: code = 7'h71;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  primed;
    logic [4*N_DIGITS-1:0] snap_digits;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_blank;
    logic                  snap_lz;

    logic                  cnt_last;
    logic                  frame_end;
    logic                  capture;
    logic                  in_active;
    logic [N_DIGITS-1:0]   blank_vec;
    logic                  above_zero;
    logic [N_DIGITS-1:0]   ac_onehot;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;

    assign cnt_last  = (cnt == CNT_LAST);
    assign frame_end = cnt_last && (idx == IDX_LAST);
    assign capture   = en && (!primed || frame_end);
    assign in_active = (DEAD == 0) ? 1'b1 : (cnt >= CNT_DEAD);

    // Walk from the most significant digit down; a digit is a leading zero while
    // everything at and above it is zero. Digit 0 always stays visible.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        blank_vec  = '0;
        above_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            above_zero   = above_zero && (snap_digits[4*i +: 4] == 4'h0);
            blank_vec[i] = snap_blank[i] || (snap_lz && above_zero && (i != 0));
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        ac_onehot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib      = snap_digits[4*i +: 4];
                cur_dp       = snap_dp[i];
                cur_blank    = blank_vec[i];
                ac_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cnt         <= '0;
            idx         <= '0;
            primed      <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_lz     <= 1'b0;
            AC          <= AC_OFF;
            SEG         <= SEG_OFF;
            DP          <= DP_OFF;
            digit_idx   <= '0;
            frame_tick  <= 1'b0;
        end else begin
            digit_idx  <= idx;
            frame_tick <= en && frame_end;
            if (capture) begin
                snap_digits <= digits;
                snap_dp     <= dp;
                snap_blank  <= blank_mask;
                snap_lz     <= lz_blank;
                primed      <= 1'b1;
            end
            if (en) begin
                if (cnt_last) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // Segments switch to the new digit during the dead phase while anodes are off.
                AC  <= (in_active && !cur_blank) ? (ac_onehot ^ AC_OFF) : AC_OFF;
                SEG <= cur_blank ? SEG_OFF : (hex_to_seg(cur_nib) ^ SEG_OFF);
                DP  <= (in_active && !cur_blank && cur_dp) ? !DP_OFF : DP_OFF;
            end else begin
                AC  <= AC_OFF;
                SEG <= SEG_OFF;
                DP  <= DP_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seletor_7seg_mux.sv
// Scoreboard bench for seletor_7seg_mux: a time-based reference model pushes the expected
// registered outputs each edge; a monitor pops and compares on the falling edge.
module tb_seletor_7seg_mux;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N * DIV;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp;
    logic [N-1:0]   blank_mask;
    logic           lz_blank;
    logic [6:0]     SEG;
    logic           DP;
    logic [N-1:0]   AC;
    logic [1:0]     digit_idx;
    logic           frame_tick;

    seletor_7seg_mux #(
        .N_DIGITS(N), .DIV(DIV), .DEAD(DEAD), .AC_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp),
        .blank_mask(blank_mask), .lz_blank(lz_blank), .SEG(SEG), .DP(DP),
        .AC(AC), .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   seg;
        bit           chk_seg;
        logic         dp;
        logic [N-1:0] ac;
        int           didx;
        logic         tick;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] seg_lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: position in the scan is just the count of enabled cycles modulo a frame.
    int           ticks   = 0;
    bit           primed  = 0;
    logic [15:0]  s_dig   = '0;
    logic [N-1:0] s_dp    = '0;
    logic [N-1:0] s_bm    = '0;
    bit           s_lz    = 0;

    initial begin
        exp_t e;
        int m_cnt, m_idx;
        logic [15:0] shifted;
        logic [N-1:0] oh;
        bit blanked, lit, act;
        forever begin
            @(posedge clk);
            if (rst) begin
                e = '{seg: 7'h7F, chk_seg: 1, dp: 1'b1, ac: '1, didx: 0, tick: 1'b0};
                ticks = 0; primed = 0; s_dig = '0; s_dp = '0; s_bm = '0; s_lz = 0;
            end else begin
                m_cnt   = ticks % DIV;
                m_idx   = ticks / DIV;
                shifted = s_dig >> (4 * m_idx);
                blanked = s_bm[m_idx] || (s_lz && m_idx > 0 && shifted == 16'h0);
                lit     = en && !blanked;
                act     = lit && (m_cnt >= DEAD);
                oh      = N'(1) << m_idx;
                e.ac      = act ? ~oh : '1;
                e.seg     = lit ? ~seg_lit[shifted[3:0]] : 7'h7F;
                e.chk_seg = !lit || (m_cnt >= DEAD);
                e.dp      = !(act && s_dp[m_idx]);
                e.didx    = m_idx;
                e.tick    = en && (ticks == FRAME - 1);
                if (en) begin
                    if (!primed || ticks == FRAME - 1) begin
                        s_dig = digits; s_dp = dp; s_bm = blank_mask; s_lz = lz_blank;
                        primed = 1;
                    end
                    ticks = (ticks + 1) % FRAME;
                end
            end
            sb.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ac", 32'(AC), 32'(e.ac));
                if (e.chk_seg) check("seg", 32'(SEG), 32'(e.seg));
                check("dp", 32'(DP), 32'(e.dp));
                check("digit_idx", 32'(digit_idx), 32'(e.didx));
                check("frame_tick", 32'(frame_tick), 32'(e.tick));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Align stimulus to a scan position using the model's own position.
    task automatic wait_pos(input int pos);
        bit found = 0;
        for (int k = 0; k < 4 * FRAME && !found; k++) begin
            @(negedge clk);
            if (ticks == pos) found = 1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL wait_pos: position %0d not reached, last %0d", pos, ticks);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; digits = '0; dp = '0; blank_mask = '0; lz_blank = 1'b0;
        cycles(3);
        rst = 1'b0; en = 1'b1; digits = 16'h1234;
        cycles(2 * FRAME + 5);

        lz_blank = 1'b1; digits = 16'h0050;
        cycles(2 * FRAME + 3);

        lz_blank = 1'b0; digits = 16'h1234;
        cycles(FRAME);
        wait_pos(DIV + 3);
        digits = 16'hABCD;
        cycles(2 * FRAME);

        dp = 4'b0100; blank_mask = 4'b0100;
        cycles(3 * FRAME);
        blank_mask = 4'b0000;
        cycles(2 * FRAME);

        wait_pos(2 * DIV + 5);
        en = 1'b0;
        cycles(10);
        en = 1'b1;
        cycles(FRAME);

        wait_pos(3 * DIV + 4);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(2 * FRAME);

        for (int it = 0; it < 150; it++) begin
            digits     = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp         = N'($urandom);
            blank_mask = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            lz_blank   = 1'($urandom);
            en         = ($urandom_range(0, 9) != 0);
            rst        = ($urandom_range(0, 39) == 0);
            cycles(1);
            rst = 1'b0;
            cycles($urandom_range(1, 24));
        end

        rst = 1'b0; en = 1'b1;
        cycles(2);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seletor_7seg_mux.md
Name: seletor_7seg_mux

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
- Parametrised successor to the fixed 4-anode segment/anode selector. Adds:
  - a refresh prescaler and a rotating one-hot anode scan;
  - hex decode with per-digit decimal point;
  - blanking mask and leading-zero suppression;
  - anti-ghosting dead time;
  - frame-coherent snapshot of the input data.
- Sits between the datapath/register file that produces BCD or hex nibbles and the board display pins.

Parameters:
- N_DIGITS, 4: number of digits/anodes, ≥1.
- DIV, 50000: clk cycles per digit slot, ≥2.
- DEAD, 500: cycles at the start of each slot with all anodes off, 0 ≤ DEAD < DIV.
- AC_ACTIVE_LOW, 1: 1 means an anode is active at 0.
- SEG_ACTIVE_LOW, 1: 1 means SEG/DP are lit at 0.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: scan enable.
- digits, input, 4*N_DIGITS: hex nibbles. Digit i is digits[4i+3:4i]; digit 0 is least significant and rightmost.
- dp, input, N_DIGITS: decimal point request per digit.
- blank_mask, input, N_DIGITS: 1 forces digit i dark.
- lz_blank, input, 1: enables leading-zero suppression.
- SEG, output, 7: segments {g,f,e,d,c,b,a}.
- DP, output, 1: decimal point.
- AC, output, N_DIGITS: anode enables, bit i drives digit i.
- digit_idx, output, clog2(N_DIGITS) (min 1): index of the current slot.
- frame_tick, output, 1: one-cycle pulse at the end of each full scan.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - cnt = 0, idx = 0, primed = 0, snapshot registers = 0.
  - AC = all inactive; SEG and DP = unlit, with the polarity set by the parameters.
  - digit_idx = 0, frame_tick = 0.
  - rst asserted mid-scan takes effect at the next edge, unconditionally.
- Prescaler:
  - cnt counts 0..DIV-1 while en = 1.
  - At cnt = DIV-1: cnt → 0 and idx advances. idx wraps from N_DIGITS-1 to 0.
- Snapshot:
  - digits, dp, blank_mask and lz_blank are captured together when en = 1 and either primed = 0, or cnt = DIV-1 with idx = N_DIGITS-1.
  - The first capture sets primed = 1.
  - The displayed data changes only at a frame boundary, so there is no tearing.
- frame_tick is registered and high for exactly the one cycle following the edge where cnt = DIV-1 and idx = N_DIGITS-1.
- Slot phases:
  - Dead phase, cnt < DEAD: AC all inactive.
  - Active phase, DEAD ≤ cnt ≤ DIV-1: AC one-hot on bit idx, unless digit idx is blanked, in which case AC is all inactive.
- Output registration:
  - SEG, DP, AC and digit_idx are registered, one cycle after the cnt/idx state that produces them.
  - DEAD = 0 gives no dead phase.
- Decode, shown for the lit=1 view; the output is inverted when SEG_ACTIVE_LOW = 1:

  | Nibble | Code | Nibble | Code |
  |---|---|---|---|
  | 0 | 3F | 8 | 7F |
  | 1 | 06 | 9 | 6F |
  | 2 | 5B | A | 77 |
  | 3 | 4F | b | 7C |
  | 4 | 66 | C | 39 |
  | 5 | 6D | d | 5E |
  | 6 | 7D | E | 79 |
  | 7 | 07 | F | 71 |

- Blanking:
  - Digit i is blanked if snapshot blank_mask[i] = 1.
  - Digit i is also blanked if snapshot lz_blank = 1, i ≥ 1, and snapshot digits N_DIGITS-1 down to i are all 0.
  - Digit 0 is never zero-suppressed.
  - A blanked digit drives SEG and DP unlit and AC inactive. Its dp bit is ignored.
- DP is lit only if snapshot dp[idx] = 1, the digit is not blanked, and the slot is in its active phase.
- en = 0:
  - cnt, idx and the snapshot hold.
  - AC goes inactive and SEG/DP go unlit from the next edge; frame_tick = 0.
  - Reasserting en resumes from the held cnt/idx.
- N_DIGITS = 1: idx stays 0, AC[0] is lit during the active phase, and frame_tick fires every DIV cycles.

Test Plan:
1. Parameters N_DIGITS=4, DIV=8, DEAD=2, both active-low. Stimulus: rst for 3 cycles, then en=1 with digits=16'h1234. Required response: AC sequence per slot is 1111 for 2 cycles, then 1110 for 6 cycles, then the same pattern with 1101, 1011, 0111. During the 1110 active phase SEG=~7'h66 (digit 0 = 4). frame_tick pulses once every 32 cycles.
2. lz_blank=1, digits=16'h0050. Required response: digits 3 and 2 are dark (AC stays 1111 in their slots). Digit 1 shows ~7'h6D and digit 0 shows ~7'h3F.
3. Change digits from 16'h1234 to 16'hABCD mid-frame (idx=1). Required response: the remainder of that frame still shows 1234. ABCD appears starting at idx=0 after frame_tick; digit 0 then shows ~7'h5E.
4. dp=4'b0100, blank_mask=4'b0100. Required response: DP is never lit and AC bit 2 stays inactive. With blank_mask=0, DP=0 only during the active phase of slot 2.
5. Deassert en at idx=2, cnt=5 for 10 cycles. Required response: AC=1111 throughout and frame_tick=0. After en returns, slot 2 resumes at cnt=5 and lasts 3 more cycles.
6. Assert rst mid-slot (idx=3). Required response: at the next edge AC=1111, SEG=7'h7F, DP=1, digit_idx=0. A fresh snapshot is taken on the first en cycle afterwards.
